// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the addr/wr_en/rd_en/wdata/rdata bus.
// Holds a DEPTH x DATA_W array. Reads return after RD_LATENCY posedges.
//
// Handshake: there is no backpressure. wr_en/rd_en are sampled on every posedge.
// Each rd_en accepted in IDLE produces exactly one rdata_valid pulse, in issue
// order. Requests seen while init_busy is high are dropped and set access_err.
//
// Optional feature: define MEM_RESPONDER_INIT_EN to make INIT sweep INIT_VALUE
// into every entry after reset. Without it, INIT lasts a single posedge.
// The FSM state is visible as the internal signal state_q for checkers.
module mem_responder #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              init_busy,
  output logic              access_err
);

  localparam int DEPTH = 1 << ADDR_W;

  // Reject unsupported configurations at elaboration time.
  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
      $error("mem_responder: RD_LATENCY must be in 1..4");
    end
    if ($bits(INIT_VALUE) != DATA_W) begin : g_bad_init_width
      $error("mem_responder: INIT_VALUE width must equal DATA_W");
    end
  endgenerate

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t state_q;

  logic [DATA_W-1:0] mem [DEPTH];

  // Stage RD_LATENCY-1 is the output register; earlier stages are the pipeline.
  logic [DATA_W-1:0] stg_data [RD_LATENCY];
  logic              stg_vld  [RD_LATENCY];

  logic              wr_fire;
  logic              rd_fire;
  logic [DATA_W-1:0] rd_word;

`ifdef MEM_RESPONDER_INIT_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  logic [ADDR_W-1:0] sweep_cnt;
`endif

  // Only IDLE accepts accesses; a same-cycle write is forwarded to the read.
  always_comb begin
    wr_fire = (state_q == ST_IDLE) && wr_en;
    rd_fire = (state_q == ST_IDLE) && rd_en;
    rd_word = wr_fire ? wdata : mem[addr];
  end

  // Control FSM: INIT (sweep or single edge) then IDLE until the next reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_busy  <= 1'b1;
      access_err <= 1'b0;
`ifdef MEM_RESPONDER_INIT_EN
      sweep_cnt  <= '0;
`endif
    end else begin
      case (state_q)
        ST_INIT: begin
          if (wr_en || rd_en) begin
            access_err <= 1'b1;
          end
`ifdef MEM_RESPONDER_INIT_EN
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == LAST_ADDR) begin
            state_q   <= ST_IDLE;
            init_busy <= 1'b0;
          end
`else
          state_q   <= ST_IDLE;
          init_busy <= 1'b0;
`endif
        end
        default: begin
          state_q   <= ST_IDLE;
          init_busy <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: init sweep writes or bus writes; reset does not clear it.
  always_ff @(posedge clk) begin
`ifdef MEM_RESPONDER_INIT_EN
    if (!reset && state_q == ST_INIT) begin
      mem[sweep_cnt] <= INIT_VALUE;
    end else if (wr_fire) begin
      mem[addr] <= wdata;
    end
`else
    if (wr_fire) begin
      mem[addr] <= wdata;
    end
`endif
  end

  // Read pipeline: data is frozen at capture and shifts one stage per edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        stg_data[i] <= '0;
        stg_vld[i]  <= 1'b0;
      end
    end else begin
      stg_vld[0] <= rd_fire;
      if (rd_fire) begin
        stg_data[0] <= rd_word;
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        stg_vld[i] <= stg_vld[i-1];
        if (stg_vld[i-1]) begin
          stg_data[i] <= stg_data[i-1];
        end
      end
    end
  end

  assign rdata       = stg_data[RD_LATENCY-1];
  assign rdata_valid = stg_vld[RD_LATENCY-1];

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (RD_LATENCY 1, 3, 4) share clock
// and reset. Reads push {expected cycle, expected data} into a per-instance
// queue; per-instance monitors pop and compare on every rdata_valid.
module tb_mem_responder;

`ifdef MEM_RESPONDER_INIT_EN
  localparam int INIT_CYC = 256;
  localparam int ATT      = 10;
  localparam logic [7:0] ATT_ADDR = 8'h07;
`else
  localparam int INIT_CYC = 1;
  localparam int ATT      = 1;
  localparam logic [7:0] ATT_ADDR = 8'h10;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       wr_en [3];
  logic       rd_en [3];
  logic [7:0] addr  [3];
  logic [7:0] wdata [3];
  logic [7:0] rdata [3];
  logic       rdata_valid [3];
  logic       init_busy   [3];
  logic       access_err  [3];

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] exp_q2[$];

  mem_responder #(.RD_LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .addr(addr[0]), .wr_en(wr_en[0]), .rd_en(rd_en[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .rdata_valid(rdata_valid[0]),
    .init_busy(init_busy[0]), .access_err(access_err[0])
  );

  mem_responder #(.RD_LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .addr(addr[1]), .wr_en(wr_en[1]), .rd_en(rd_en[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .rdata_valid(rdata_valid[1]),
    .init_busy(init_busy[1]), .access_err(access_err[1])
  );

  mem_responder #(.RD_LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .addr(addr[2]), .wr_en(wr_en[2]), .rd_en(rd_en[2]),
    .wdata(wdata[2]), .rdata(rdata[2]), .rdata_valid(rdata_valid[2]),
    .init_busy(init_busy[2]), .access_err(access_err[2])
  );

  // ---------------- helpers ----------------
  function automatic int lat_of(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input int k, input logic [7:0] d);
    logic [31:0] e;
    e = {24'(cyc + lat_of(k)), d};
    case (k)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  // ---------------- driver tasks ----------------
  // Called right after a negedge; the request is sampled on the next posedge.
  task automatic op(input int k, input logic we, input logic re, input logic [7:0] a,
                    input logic [7:0] d, input logic [7:0] e, input bit track);
    wr_en[k] = we;
    rd_en[k] = re;
    addr[k]  = a;
    wdata[k] = d;
    if (re && track) push_exp(k, e);
    @(negedge clk);
    wr_en[k] = 1'b0;
    rd_en[k] = 1'b0;
  endtask

  task automatic wr(input int k, input logic [7:0] a, input logic [7:0] d);
    op(k, 1'b1, 1'b0, a, d, 8'h00, 1'b0);
  endtask

  task automatic rd(input int k, input logic [7:0] a, input logic [7:0] e);
    op(k, 1'b0, 1'b1, a, 8'h00, e, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Release reset, optionally poke instance 0 during INIT, and time init_busy.
  task automatic release_and_init(input bit attempt);
    bit done;
    done  = 1'b0;
    reset = 1'b0;
    for (int n = 0; n <= 4000; n++) begin
      if (attempt && n == ATT) begin
        wr_en[0] = 1'b0;
        check("access_err_set", 32'(access_err[0]), 32'd1);
      end
      if (n > 0 && !init_busy[0]) begin
        check("init_posedges", n, INIT_CYC);
        check("init_busy_l3", 32'(init_busy[1]), 32'd0);
        check("init_busy_l4", 32'(init_busy[2]), 32'd0);
        done = 1'b1;
        break;
      end
      if (attempt && n == ATT - 1) begin
        check("access_err_before", 32'(access_err[0]), 32'd0);
        wr_en[0] = 1'b1;
        addr[0]  = ATT_ADDR;
        wdata[0] = 8'hFF;
      end
      @(negedge clk);
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL init_timeout: init_busy still 1 after 4000 posedges, required 0 after %0d", INIT_CYC);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic mon(input int k);
    logic [31:0] e;
    bit have;
    have = 1'b0;
    e    = '0;
    case (k)
      0:       if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
      1:       if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
      default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); have = 1'b1; end
    endcase
    check($sformatf("busy_with_valid_%0d", k), 32'(init_busy[k]), 32'd0);
    if (!have) begin
      n_vec++;
      n_bad++;
      $display("FAIL unexpected_resp_%0d: got rdata_valid=1 (rdata %0h), required no response", k, rdata[k]);
    end else begin
      check($sformatf("rdata_%0d", k), 32'(rdata[k]), 32'(e[7:0]));
      check($sformatf("resp_cycle_%0d", k), cyc, 32'(e[31:8]));
    end
  endtask

  always @(negedge clk) if (rdata_valid[0]) mon(0);
  always @(negedge clk) if (rdata_valid[1]) mon(1);
  always @(negedge clk) if (rdata_valid[2]) mon(2);

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wr_en[k] = 1'b0;
      rd_en[k] = 1'b0;
      addr[k]  = 8'h00;
      wdata[k] = 8'h00;
    end
    idle(2);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_rdata_%0d", k), 32'(rdata[k]), 32'd0);
      check($sformatf("rst_valid_%0d", k), 32'(rdata_valid[k]), 32'd0);
      check($sformatf("rst_err_%0d", k), 32'(access_err[k]), 32'd0);
      check($sformatf("rst_busy_%0d", k), 32'(init_busy[k]), 32'd1);
    end
    release_and_init(1'b0);

    // Latency 1: basic write/read, then same-cycle write+read to one address.
    wr(0, 8'h10, 8'hA5);
    rd(0, 8'h10, 8'hA5);
    wr(0, 8'h20, 8'h11);
    op(0, 1'b1, 1'b1, 8'h20, 8'h22, 8'h22, 1'b1);
    rd(0, 8'h20, 8'h22);

    // Latency 3: streaming reads, plus top/bottom address without aliasing.
    wr(1, 8'h00, 8'h01);
    wr(1, 8'h01, 8'h02);
    wr(1, 8'h02, 8'h03);
    rd(1, 8'h00, 8'h01);
    rd(1, 8'h01, 8'h02);
    rd(1, 8'h02, 8'h03);
    wr(1, 8'hFF, 8'h5C);
    rd(1, 8'hFF, 8'h5C);
    rd(1, 8'h00, 8'h01);

    // Latency 4: an in-flight read keeps its captured word.
    wr(2, 8'h05, 8'h33);
    rd(2, 8'h05, 8'h33);
    wr(2, 8'h05, 8'h44);
    idle(6);
    rd(2, 8'h05, 8'h44);

    idle(8);
    check("queues_drained", exp_q0.size() + exp_q1.size() + exp_q2.size(), 0);

    // Reset with two reads in flight on the latency-4 instance.
    op(2, 1'b0, 1'b1, 8'h05, 8'h00, 8'h00, 1'b0);
    op(2, 1'b0, 1'b1, 8'h05, 8'h00, 8'h00, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_rdata", 32'(rdata[2]), 32'd0);
    check("midrst_valid", 32'(rdata_valid[2]), 32'd0);
    check("midrst_err", 32'(access_err[2]), 32'd0);
    check("midrst_rdata_l3", 32'(rdata[1]), 32'd0);
    idle(3);
    release_and_init(1'b1);

    // Ignored INIT-time write must not have changed the array.
`ifdef MEM_RESPONDER_INIT_EN
    rd(0, 8'h00, 8'h00);
    rd(0, 8'h07, 8'h00);
    rd(0, 8'hFF, 8'h00);
    rd(0, 8'h10, 8'h00);
`else
    rd(0, 8'h10, 8'hA5);
`endif
    idle(8);
    check("err_sticky", 32'(access_err[0]), 32'd1);
    check("err_other", 32'(access_err[1]), 32'd0);
    check("queues_final", exp_q0.size() + exp_q1.size() + exp_q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
